extreme_seq: RTL and testbench

Sequential extreme-value finder built around the mode comparator datapath (N-bit magnitude compare plus 2:1 select). It accepts a start command with a frame length and mode, then consumes one operand per accepted valid/ready beat. It keeps a running maximum or minimum in an accumulator register. When the frame ends it presents the extreme value and, optionally, its position in the frame. It sits between a streaming operand source and any consumer that needs per-frame max/min statistics.

---
 rtl/extreme_seq.sv | 173 +++++++++++++++++
 tb/tb_extreme_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/extreme_seq.sv
// extreme_seq: sequential per-frame maximum/minimum finder.
// A start command latches the frame length and mode. The block then takes one
// operand per accepted valid/ready beat and keeps a running extreme in an
// accumulator. It reports that extreme, and optionally its frame position,
// with a one-cycle done pulse.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start, m, len    frame command (m: 0 = max, 1 = min), sampled in IDLE
//   in_valid, din    operand stream; in_ready accepts a beat
//   busy             high while the frame is loading or running
//   done             one-cycle pulse when y/idx become valid
//   y, idx           extreme of the last frame and its 0-based position
//
// Build option: define EXTREME_SEQ_IDX_EN to implement the position register.
// When it is undefined, idx is constant 0.
module extreme_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             m,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     din,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     y,
    output logic [LEN_W-1:0] idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             m_q, m_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [N-1:0]     acc_q, acc_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     y_q, y_d;
`ifdef EXTREME_SEQ_IDX_EN
    logic [LEN_W-1:0] pos_q, pos_d;
    logic [LEN_W-1:0] idx_q, idx_d;
`endif

    logic             accept;
    logic             take_din;
    logic [LEN_W-1:0] count_inc;

    // Shared comparator: max takes din on ties (din >= acc), min keeps acc on ties.
    assign accept    = in_valid & in_ready_q;
    assign take_din  = m_q ? (acc_q > din) : !(acc_q > din);
    assign count_inc = count_q + LEN_W'(1);

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        len_d   = len_q;
        count_d = count_q;
        acc_d   = acc_q;
`ifdef EXTREME_SEQ_IDX_EN
        pos_d   = pos_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        m_d     = m;
                        len_d   = len;
                        count_d = '0;
                        state_d = S_LOAD;
                    end else begin
                        // Empty frame reports zero
                        acc_d   = '0;
`ifdef EXTREME_SEQ_IDX_EN
                        pos_d   = '0;
`endif
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    acc_d   = din;
`ifdef EXTREME_SEQ_IDX_EN
                    pos_d   = '0;
`endif
                    count_d = LEN_W'(1);
                    state_d = (len_q == LEN_W'(1)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (take_din) begin
                        acc_d = din;
`ifdef EXTREME_SEQ_IDX_EN
                        pos_d = count_q;
`endif
                    end
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the state being entered so they are valid from that cycle
        in_ready_d = (state_d == S_LOAD) || (state_d == S_RUN);
        busy_d     = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        y_d        = (state_d == S_DONE) ? acc_d : y_q;
`ifdef EXTREME_SEQ_IDX_EN
        idx_d      = (state_d == S_DONE) ? pos_d : idx_q;
`endif
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            m_q        <= 1'b0;
            len_q      <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= '0;
`ifdef EXTREME_SEQ_IDX_EN
            pos_q      <= '0;
            idx_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            len_q      <= len_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            y_q        <= y_d;
`ifdef EXTREME_SEQ_IDX_EN
            pos_q      <= pos_d;
            idx_q      <= idx_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign y        = y_q;
`ifdef EXTREME_SEQ_IDX_EN
    assign idx      = idx_q;
`else
    assign idx      = '0;
`endif

endmodule

// File: tb/tb_extreme_seq.sv
// tb_extreme_seq: self-checking bench for extreme_seq.
// Expected results come from a behavioural max/min model. They are queued when
// a frame is started and compared when done pulses, together with the done
// latency counted in clock edges after the start edge.
module tb_extreme_seq;

    localparam int unsigned N     = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             m;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     din;
    logic             busy;
    logic             done;
    logic [N-1:0]     y;
    logic [LEN_W-1:0] idx;

    typedef struct {
        logic [N-1:0]     y;
        logic [LEN_W-1:0] idx;
        int               lat;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] ops[16];
    int           n_checks = 0;
    int           n_fail   = 0;

    extreme_seq #(.N(N), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m        (m),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .y        (y),
        .idx      (idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: max takes newer on ties, min keeps older
    task automatic push_expected(input logic mode, input int l, input int gap);
        exp_t e;
        e.y   = '0;
        e.idx = '0;
        if (l > 0) begin
            e.y = ops[0];
            for (int i = 1; i < l; i++) begin
                if (mode ? (ops[i] < e.y) : (ops[i] >= e.y)) begin
                    e.y   = ops[i];
                    e.idx = LEN_W'(i);
                end
            end
        end
`ifndef EXTREME_SEQ_IDX_EN
        e.idx = '0;
`endif
        e.lat = (l == 0) ? 0 : l + gap * (l - 1);
        sb.push_back(e);
    endtask

    // Drives one frame from ops[]; inputs change 1 time unit after each rising edge
    task automatic run_frame(input logic mode, input int l, input int gap,
                             input bit start_mid, input bit hold_valid, input int abort_after);
        int   e    = 0;
        int   beat = 0;
        int   bub  = 0;
        bit   acc;
        exp_t x;
        if (abort_after == 0) push_expected(mode, l, gap);
        start    = 1'b1;
        m        = mode;
        len      = LEN_W'(l);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        m     = ~mode;
        len   = LEN_W'(l + 3);
        if (l > 0) begin
            check("ready_cycle1", 32'(in_ready), 32'd1);
            check("busy_cycle1", 32'(busy), 32'd1);
        end
        while (e < 100) begin
            if (done) break;
            in_valid = (beat < l) && (bub == 0);
            din      = in_valid ? ops[beat] : 8'h5A;
            if (start_mid && beat == 2) begin
                start = 1'b1;
                len   = '0;
            end else begin
                start = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            e++;
            if (acc) begin
                beat++;
                bub = gap;
            end else if (bub > 0) begin
                bub--;
            end
            if (abort_after > 0 && beat == abort_after) begin
                in_valid = 1'b0;
                start    = 1'b0;
                #2 rst = 1'b1;
                #1;
                check("rst_in_ready", 32'(in_ready), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_y", 32'(y), 32'd0);
                check("rst_idx", 32'(idx), 32'd0);
                #1 rst = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            check("y", 32'(y), 32'(x.y));
            check("idx", 32'(idx), 32'(x.idx));
            check("done_latency", 32'(e), 32'(x.lat));
            check("ready_in_done", 32'(in_ready), 32'd0);
            in_valid = hold_valid;
            din      = 8'hAA;
            @(posedge clk);
            #1;
            check("done_one_cycle", 32'(done), 32'd0);
            check("ready_in_idle", 32'(in_ready), 32'd0);
            check("y_hold", 32'(y), 32'(x.y));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        m        = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        din      = '0;
        #12;
        check("reset_ready", 32'(in_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_idx", 32'(idx), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Max frame, valid held high through DONE/IDLE afterwards
        ops[0] = 8'd3; ops[1] = 8'd9; ops[2] = 8'd2; ops[3] = 8'd7;
        run_frame(1'b0, 4, 0, 1'b0, 1'b1, 0);

        // Min frame with one bubble between beats
        ops[0] = 8'd20; ops[1] = 8'd5; ops[2] = 8'd8;
        run_frame(1'b1, 3, 1, 1'b0, 1'b0, 0);

        // Tie rules
        ops[0] = 8'd6; ops[1] = 8'd6; ops[2] = 8'd6;
        run_frame(1'b0, 3, 0, 1'b0, 1'b0, 0);
        run_frame(1'b1, 3, 0, 1'b0, 1'b0, 0);

        // Boundaries
        run_frame(1'b0, 0, 0, 1'b0, 1'b0, 0);
        ops[0] = 8'hFF;
        run_frame(1'b1, 1, 0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 15; i++) ops[i] = 8'(i);
        run_frame(1'b0, 15, 0, 1'b0, 1'b1, 0);

        // start pulsed during RUN is ignored
        ops[0] = 8'd1; ops[1] = 8'd2; ops[2] = 8'd3; ops[3] = 8'd4;
        run_frame(1'b0, 4, 0, 1'b1, 1'b0, 0);

        // Reset after second beat, then a fresh frame
        ops[0] = 8'd50; ops[1] = 8'd60; ops[2] = 8'd70; ops[3] = 8'd80;
        run_frame(1'b0, 4, 0, 1'b0, 1'b0, 2);
        ops[0] = 8'd9; ops[1] = 8'd4; ops[2] = 8'd4; ops[3] = 8'd7;
        run_frame(1'b1, 4, 0, 1'b0, 1'b0, 0);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            int l;
            l = int'($urandom_range(1, 15));
            for (int i = 0; i < 16; i++) ops[i] = 8'($urandom_range(0, 255));
            run_frame(1'($urandom_range(0, 1)), l, int'($urandom_range(0, 2)), 1'b0, 1'b0, 0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
